// File: rtl/mem_access_pkg.sv
// ============================================================================
//  Packages : common, pipes
//  Shared data-bus and pipeline record types for the memory stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package common;

  typedef enum logic [1:0] {
    MSIZE1 = 2'b00,
    MSIZE2 = 2'b01,
    MSIZE4 = 2'b10,
    MSIZE8 = 2'b11
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // Byte-lane mask of an aligned access of the given size, before lane shift.
  function automatic logic [7:0] size_mask(input msize_t size);
    logic [7:0] mask;
    case (size)
      MSIZE1:  mask = 8'h01;
      MSIZE2:  mask = 8'h03;
      MSIZE4:  mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

package pipes;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    ADD    = 3'd1,
    SUB    = 3'd2,
    LD     = 3'd3,
    SD     = 3'd4,
    BRANCH = 3'd5
  } decoded_op_t;

  typedef enum logic [1:0] {
    NOERROR  = 2'd0,
    ILLEGAL  = 2'd1,
    MISALIGN = 2'd2
  } error_t;

  typedef struct packed {
    decoded_op_t op;
    logic [2:0]  funct3;
    logic        regwrite;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] srcb;
    error_t      error;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    error_t      error;
  } memory_data_t;

  function automatic memory_data_t to_memory(input execute_data_t e);
    memory_data_t m;
    m.valid  = e.valid;
    m.pc     = e.pc;
    m.ctl    = e.ctl;
    m.dst    = e.dst;
    m.result = e.result;
    m.error  = e.error;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_align.sv
// ============================================================================
//  Module   : mem_align
//  Extracts the addressed lanes of a 64-bit load and sign/zero-extends them.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_align
  import common::*;
(
  input  logic [63:0] raw_i,
  input  logic [2:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] result_o
);

  logic [63:0] w_shifted;
  logic        w_unsigned;

  assign w_shifted  = raw_i >> {addr_i, 3'b000};
  assign w_unsigned = funct3_i[2];

  always_comb begin
    result_o = w_shifted;
    case (msize_t'(funct3_i[1:0]))
      MSIZE1: result_o = w_unsigned ? {56'd0, w_shifted[7:0]}
                                    : {{56{w_shifted[7]}}, w_shifted[7:0]};
      MSIZE2: result_o = w_unsigned ? {48'd0, w_shifted[15:0]}
                                    : {{48{w_shifted[15]}}, w_shifted[15:0]};
      MSIZE4: result_o = w_unsigned ? {32'd0, w_shifted[31:0]}
                                    : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: result_o = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
//  Module   : mem_access
//  Memory stage: issues one data-bus request per LD/SD and returns the result.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
  import common::*;
  import pipes::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          flushall,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stallm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [63:0] addr_q,   addr_d;
  msize_t      size_q,   size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q,  wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q,  store_d;
  logic        kill_q,   kill_d;
  logic [63:0] rdata_q,  rdata_d;

  logic        is_mem;
  logic [63:0] load_ext;
  logic        unused_addr_ok;

  // Only data_ok advances the transaction; addr_ok carries no state here.
  assign unused_addr_ok = dresp.addr_ok;

  assign is_mem = dataE.valid && (dataE.error == NOERROR) &&
                  ((dataE.ctl.op == LD) || (dataE.ctl.op == SD));

  mem_align u_align (
    .raw_i    (dresp.data),
    .addr_i   (addr_q[2:0]),
    .funct3_i (funct3_q),
    .result_o (load_ext)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    kill_d   = kill_q;
    rdata_d  = rdata_q;

    dreq.valid  = 1'b0;
    dreq.addr   = addr_q;
    dreq.size   = size_q;
    dreq.strobe = strobe_q;
    dreq.data   = wdata_q;
    dataM       = to_memory(dataE);
    stallm      = 1'b0;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (is_mem) begin
          dataM.valid = 1'b0;
          stallm      = 1'b1;
          if (!flushall) begin
            state_d  = BUSY;
            addr_d   = dataE.result;
            size_d   = msize_t'(dataE.ctl.funct3[1:0]);
            strobe_d = size_mask(msize_t'(dataE.ctl.funct3[1:0])) << dataE.result[2:0];
            wdata_d  = dataE.srcb << {dataE.result[2:0], 3'b000};
            funct3_d = dataE.ctl.funct3;
            store_d  = (dataE.ctl.op == SD);
          end
        end
      end

      BUSY: begin
        dreq.valid  = 1'b1;
        dataM.valid = 1'b0;
        stallm      = 1'b1;
        if (flushall) begin
          kill_d = 1'b1;
        end
        if (dresp.data_ok) begin
          state_d = DONE;
          rdata_d = store_q ? addr_q : load_ext;
        end
      end

      DONE: begin
        // Upstream still holds this record; release it without re-issuing.
        dataM.valid  = !kill_q && !flushall;
        dataM.result = rdata_q;
        if (store_q) begin
          dataM.ctl.regwrite = 1'b0;
        end
        state_d = IDLE;
        kill_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      kill_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      kill_q   <= kill_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

`default_nettype wire
